acc_ctrl: RTL and testbench

//  Accumulator/sequencer that drives the 4-bit ripple-carry adder (rca) and registers its result.
//  - Drives rca operands A/B and captures rca SUM into the accumulator ACC.
//  - Sets Z/N/V flags; rca has no carry-in or carry-out, so no C flag.
//  - Builds SUB from two rca passes: ACC + ~DATA, then + 1.
//  - Sits between the instruction/operand source (upstream) and the rca (downstream).

---
 rtl/acc_ctrl_if.sv | 29 ++
 rtl/acc_ctrl.sv | 150 +++++++++++++++
 tb/tb_acc_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/acc_ctrl_if.sv
// acc_ctrl_if: command handshake, rca operand/result bus and result/flag
// outputs of the accumulator controller. The slave side is acc_ctrl; the
// master side is the upstream command source together with the rca.
interface acc_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] acc;
  logic             out_valid;
  logic             z;
  logic             n;
  logic             v;

  modport slave (
    input  in_valid, op, data, sum,
    output in_ready, a, b, acc, out_valid, z, n, v
  );

  modport master (
    output in_valid, op, data, sum,
    input  in_ready, a, b, acc, out_valid, z, n, v
  );
endinterface

// File: rtl/acc_ctrl.sv
// acc_ctrl: accumulator/sequencer driving an external ripple-carry adder.
// LOAD/CLR complete in one cycle, ADD uses one adder pass, SUB uses two
// passes (ACC + ~DATA, then + 1). Flags Z/N/V hold between operations.
// Optional feature macro: ACC_SAT_EN -- when defined, a signed overflow on
// ADD/SUB saturates ACC toward the sign of the old ACC (V still reads 1).
module acc_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  acc_ctrl_if.slave   bus
);

  localparam int MSB = WIDTH - 1;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, EX1, EX2, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, opnd_q, temp_q;
  logic [1:0]       op_q;
  logic             z_q, n_q, v_q;

  logic             accept;
  logic             is_sub;
  logic             ovf;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic             ready_sel, ovalid_sel;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign is_sub = (op_q == OP_SUB);

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: ADD/SUB go through the adder, LOAD/CLR go straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = ((bus.op == OP_ADD) || (bus.op == OP_SUB)) ? EX1 : DONE;
      EX1:  state_d = is_sub ? EX2 : DONE;
      EX2:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: adder operand selection and handshake per state.
  always_comb begin
    a_sel      = acc_q;
    b_sel      = '0;
    ready_sel  = 1'b0;
    ovalid_sel = 1'b0;
    case (state_q)
      IDLE: ready_sel = 1'b1;
      EX1:  b_sel = is_sub ? ~opnd_q : opnd_q;
      EX2: begin
        a_sel = temp_q;
        b_sel = ONE;
      end
      DONE: ovalid_sel = 1'b1;
      default: ready_sel = 1'b0;
    endcase
  end

  // Overflow and stored result of the final adder pass; acc_q still holds
  // the old ACC here, and for SUB the EX2 sum is the complete difference.
  always_comb begin
    if (is_sub)
      ovf = (acc_q[MSB] != opnd_q[MSB]) && (bus.sum[MSB] != acc_q[MSB]);
    else
      ovf = (acc_q[MSB] == opnd_q[MSB]) && (bus.sum[MSB] != acc_q[MSB]);
    res = bus.sum;
`ifdef ACC_SAT_EN
    if (ovf) res = acc_q[MSB] ? SAT_NEG : SAT_POS;
`else
    if (ovf) res = bus.sum;
`endif
  end

  // Datapath: command capture, accumulator, temp and flag registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q  <= '0;
      opnd_q <= '0;
      temp_q <= '0;
      op_q   <= OP_LOAD;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            opnd_q <= bus.data;
            op_q   <= bus.op;
            if (bus.op == OP_LOAD) begin
              acc_q <= bus.data;
              z_q   <= (bus.data == '0);
              n_q   <= bus.data[MSB];
              v_q   <= 1'b0;
            end else if (bus.op == OP_CLR) begin
              acc_q <= '0;
              z_q   <= 1'b1;
              n_q   <= 1'b0;
              v_q   <= 1'b0;
            end
          end
        end
        EX1: begin
          if (is_sub) begin
            temp_q <= bus.sum;
          end else begin
            acc_q <= res;
            z_q   <= (res == '0);
            n_q   <= res[MSB];
            v_q   <= ovf;
          end
        end
        EX2: begin
          acc_q <= res;
          z_q   <= (res == '0);
          n_q   <= res[MSB];
          v_q   <= ovf;
        end
        default: acc_q <= acc_q;
      endcase
    end
  end

  assign bus.a         = a_sel;
  assign bus.b         = b_sel;
  assign bus.in_ready  = ready_sel;
  assign bus.out_valid = ovalid_sel;
  assign bus.acc       = acc_q;
  assign bus.z         = z_q;
  assign bus.n         = n_q;
  assign bus.v         = v_q;

endmodule

// File: tb/tb_acc_ctrl.sv
// tb_acc_ctrl: acc_ctrl with a behavioural 4-bit adder, directed and random
// commands checked against a signed-integer reference model.
module tb_acc_ctrl;
  localparam int W = 4;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acc_ctrl_if #(.WIDTH(W)) bus ();
  // Behavioural rca: combinational, no carry-in/carry-out.
  assign bus.sum = bus.a + bus.b;

  acc_ctrl #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [3:0] acc_m;
  logic       z_m, n_m, v_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input logic [3:0] x);
    return x[3] ? int'(x) - 16 : int'(x);
  endfunction

  // Signed-integer model of one command.
  task automatic model(input logic [1:0] op, input logic [3:0] d);
    int sa, sd, r;
    bit ov;
    sa = to_signed(acc_m);
    sd = to_signed(d);
    ov = 1'b0;
    case (op)
      OP_LOAD: r = sd;
      OP_CLR:  r = 0;
      OP_ADD:  r = sa + sd;
      default: r = sa - sd;
    endcase
    if ((op == OP_ADD || op == OP_SUB) && (r > 7 || r < -8)) ov = 1'b1;
`ifdef ACC_SAT_EN
    if (ov) r = (sa < 0) ? -8 : 7;
`endif
    acc_m = 4'(r & 15);
    z_m = (acc_m == 4'd0);
    n_m = acc_m[3];
    v_m = ov;
  endtask

  function automatic int exp_lat(input logic [1:0] op);
    case (op)
      OP_ADD:  return 2;
      OP_SUB:  return 3;
      default: return 1;
    endcase
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_acc"}, 32'(bus.acc), 32'(acc_m));
    chk({tag, "_z"}, 32'(bus.z), 32'(z_m));
    chk({tag, "_n"}, 32'(bus.n), 32'(n_m));
    chk({tag, "_v"}, 32'(bus.v), 32'(v_m));
  endtask

  // One command: present it, wait for OUT_VALID, check result and that
  // nothing else happens in the two following cycles.
  task automatic do_op(input logic [1:0] op, input logic [3:0] d, input bit hold);
    int lat;
    bit seen;
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.data = d;
    @(posedge clk);
    if (!hold) begin
      #1 bus.in_valid = 1'b0;
    end
    model(op, d);
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clk);
      lat = i;
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    chk("out_valid_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat(op)));
    check_state("result");
    $display("op=%0d data=%h hold=%0d lat=%0d acc=%h z=%0d n=%0d v=%0d",
             op, d, hold, lat, bus.acc, bus.z, bus.n, bus.v);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("out_valid_pulse", 32'(bus.out_valid), 32'd0);
    check_state("held1");
    @(negedge clk);
    chk("no_repeat", 32'(bus.out_valid), 32'd0);
    check_state("held2");
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.op = OP_LOAD;
    bus.data = 4'd0;
    acc_m = 4'd0; z_m = 1'b0; n_m = 1'b0; v_m = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_state("rst");
    rst_n = 1'b1;

    // Directed cases
    do_op(OP_LOAD, 4'b0011, 1'b0);
    do_op(OP_ADD,  4'b0100, 1'b0);
    chk("spec_add_acc", 32'(bus.acc), 32'h7);

    do_op(OP_LOAD, 4'b0101, 1'b0);
    do_op(OP_ADD,  4'b1001, 1'b0);
    chk("spec_add_neg", 32'(bus.acc), 32'he);
    do_op(OP_ADD,  4'b1101, 1'b0);
    chk("spec_add_neg2", 32'(bus.acc), 32'hb);

    do_op(OP_LOAD, 4'b0010, 1'b0);
    do_op(OP_SUB,  4'b0101, 1'b0);
    chk("spec_sub_acc", 32'(bus.acc), 32'hd);
    do_op(OP_SUB,  4'b1101, 1'b0);
    chk("spec_sub_zero", 32'(bus.z), 32'd1);

    do_op(OP_LOAD, 4'b0111, 1'b0);
    do_op(OP_ADD,  4'b0001, 1'b0);
`ifdef ACC_SAT_EN
    chk("spec_ovf_add", 32'(bus.acc), 32'h7);
`else
    chk("spec_ovf_add", 32'(bus.acc), 32'h8);
`endif
    chk("spec_ovf_add_v", 32'(bus.v), 32'd1);
    do_op(OP_LOAD, 4'b0000, 1'b0);
    do_op(OP_SUB,  4'b1000, 1'b0);
`ifdef ACC_SAT_EN
    chk("spec_ovf_sub", 32'(bus.acc), 32'h7);
`else
    chk("spec_ovf_sub", 32'(bus.acc), 32'h8);
`endif
    chk("spec_ovf_sub_v", 32'(bus.v), 32'd1);
    do_op(OP_CLR,  4'b1010, 1'b0);

    // Handshake: IN_VALID held high through a SUB
    do_op(OP_LOAD, 4'b0110, 1'b1);
    do_op(OP_SUB,  4'b0010, 1'b1);

    // Reset during EX1
    do_op(OP_LOAD, 4'b0011, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = OP_ADD;
    bus.data = 4'b0001;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    rst_n = 1'b0;
    acc_m = 4'd0; z_m = 1'b0; n_m = 1'b0; v_m = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check_state("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("after_rst_no_valid", 32'(bus.out_valid), 32'd0);
    check_state("after_rst");

    // Randomized commands
    for (int k = 0; k < 150; k++) begin
      logic [1:0] rop;
      logic [3:0] rd;
      bit rh;
      rop = 2'($urandom_range(0, 3));
      rd  = 4'($urandom_range(0, 15));
      rh  = ($urandom_range(0, 3) == 0);
      do_op(rop, rd, rh);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
